// File: rtl/cp0_unit.sv
// Coprocessor 0 for the 5-stage MIPS core: SR/Cause/EPC/PRId, exception and interrupt request, mfc0/mtc0/eret.
// Optional Count register at address 9 when CP0_COUNT_EN is defined.
module cp0_unit #(
  parameter logic [4:0]  NONE_CODE = 5'd0,
  parameter logic [31:0] PRID_VAL  = 32'h0000_2023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;
  localparam logic [4:0] ADDR_COUNT = 5'd9;

  logic [5:0]  sr_im_r;
  logic        sr_exl_r;
  logic        sr_ie_r;
  logic        cause_bd_r;
  logic [5:0]  cause_ip_r;
  logic [4:0]  cause_exc_r;
  logic [31:0] epc_r;

  logic [5:0]  sr_im_nx_s;
  logic        sr_exl_nx_s;
  logic        sr_ie_nx_s;
  logic        cause_bd_nx_s;
  logic [4:0]  cause_exc_nx_s;
  logic [31:0] epc_nx_s;

  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic [31:0] epc_base_s;
  logic [31:0] sr_word_s;
  logic [31:0] cause_word_s;

  // Request decode; deliberately independent of we/cp0_wdata.
  always_comb begin
    int_req_s = (|(hw_int & sr_im_r)) & sr_ie_r & ~sr_exl_r;
    exc_req_s = (exc_code_in != NONE_CODE) & ~sr_exl_r;
    req_s     = int_req_s | exc_req_s;
  end

  assign epc_base_s = vpc & 32'hFFFF_FFFC;

  // Next-state for SR, Cause and EPC: a request overrides any mtc0 or eret on the same edge.
  always_comb begin
    sr_im_nx_s     = sr_im_r;
    sr_exl_nx_s    = sr_exl_r;
    sr_ie_nx_s     = sr_ie_r;
    cause_bd_nx_s  = cause_bd_r;
    cause_exc_nx_s = cause_exc_r;
    epc_nx_s       = epc_r;
    if (req_s) begin
      sr_exl_nx_s    = 1'b1;
      cause_bd_nx_s  = bd_in;
      cause_exc_nx_s = int_req_s ? 5'd0 : exc_code_in;
      epc_nx_s       = bd_in ? (epc_base_s - 32'd4) : epc_base_s;
    end else begin
      if (we) begin
        case (cp0_addr)
          ADDR_SR: begin
            sr_im_nx_s  = cp0_wdata[15:10];
            sr_exl_nx_s = cp0_wdata[1];
            sr_ie_nx_s  = cp0_wdata[0];
          end
          ADDR_EPC: begin
            epc_nx_s = cp0_wdata;
          end
          default: begin
            epc_nx_s = epc_r;
          end
        endcase
      end else begin
        epc_nx_s = epc_r;
      end
      // eret wins over a simultaneous mtc0 for the EXL bit only.
      if (exl_clr) begin
        sr_exl_nx_s = 1'b0;
      end else begin
        sr_exl_nx_s = sr_exl_nx_s;
      end
    end
  end

  // SR, Cause and EPC state; IP samples the raw interrupt lines every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_r     <= 6'd0;
      sr_exl_r    <= 1'b0;
      sr_ie_r     <= 1'b0;
      cause_bd_r  <= 1'b0;
      cause_ip_r  <= 6'd0;
      cause_exc_r <= 5'd0;
      epc_r       <= 32'd0;
    end else begin
      sr_im_r     <= sr_im_nx_s;
      sr_exl_r    <= sr_exl_nx_s;
      sr_ie_r     <= sr_ie_nx_s;
      cause_bd_r  <= cause_bd_nx_s;
      cause_ip_r  <= hw_int;
      cause_exc_r <= cause_exc_nx_s;
      epc_r       <= epc_nx_s;
    end
  end

`ifdef CP0_COUNT_EN
  logic [31:0] count_r;
  logic [31:0] count_nx_s;

  // Free-running counter; an accepted mtc0 replaces the increment, a request does not.
  always_comb begin
    count_nx_s = count_r + 32'd1;
    if (we && !req_s && (cp0_addr == ADDR_COUNT)) begin
      count_nx_s = cp0_wdata;
    end else begin
      count_nx_s = count_r + 32'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 32'd0;
    end else begin
      count_r <= count_nx_s;
    end
  end
`endif

  assign sr_word_s    = {16'd0, sr_im_r, 8'd0, sr_exl_r, sr_ie_r};
  assign cause_word_s = {cause_bd_r, 15'd0, cause_ip_r, 3'd0, cause_exc_r, 2'd0};

  // mfc0 read mux; no bypass of same-edge writes.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr_word_s;
      ADDR_CAUSE: cp0_rdata = cause_word_s;
      ADDR_EPC:   cp0_rdata = epc_r;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
`ifdef CP0_COUNT_EN
      ADDR_COUNT: cp0_rdata = count_r;
`endif
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out = epc_r;
  assign req     = req_s;

endmodule
